// File: rtl/accum_table_wr_control.sv
// Write-side address/strobe generator for the accumulator table: replays the
// skewed drain wavefront of the systolic array, one bank per array column.
module accum_table_wr_control #(
   parameter  int MAX_OUT_ROWS   = 128,
   parameter  int MAX_OUT_COLS   = 128,
   parameter  int SYS_ARR_ROWS   = 16,
   parameter  int SYS_ARR_COLS   = 16,
   localparam int NUM_SUBMATS_M  = MAX_OUT_ROWS / SYS_ARR_ROWS,
   localparam int NUM_SUBMATS_N  = MAX_OUT_COLS / SYS_ARR_COLS,
   localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * NUM_SUBMATS_N,
   localparam int ADDR_W         = $clog2(NUM_ACCUM_ROWS),
   localparam int M_W            = $clog2(NUM_SUBMATS_M),
   localparam int N_W            = $clog2(NUM_SUBMATS_N)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [M_W-1:0]                 submat_m,
   input  logic [N_W-1:0]                 submat_n,
   input  logic                           accum,
   output logic [SYS_ARR_COLS-1:0]        wr_en,
   output logic [ADDR_W*SYS_ARR_COLS-1:0] wr_addr,
   output logic [SYS_ARR_COLS-1:0]        accum_en,
   output logic                           busy,
   output logic                           done,
   output logic                           state_dbg
);

   localparam int T_W = $clog2(SYS_ARR_ROWS + SYS_ARR_COLS - 1);
   localparam logic [T_W-1:0] T_LAST = T_W'(SYS_ARR_ROWS + SYS_ARR_COLS - 2);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t                         state, state_nx;
   logic [T_W-1:0]                 t, t_nx;
   logic [M_W-1:0]                 m_q, m_nx;
   logic [N_W-1:0]                 n_q, n_nx;
   logic                           acc_q, acc_nx;
   logic                           active_nx;
   logic                           done_nx;
   logic                           in_range;
   logic [ADDR_W-1:0]              base_nx;
   logic [SYS_ARR_COLS-1:0]        wr_en_nx;
   logic [SYS_ARR_COLS-1:0]        accum_en_nx;
   logic [ADDR_W*SYS_ARR_COLS-1:0] wr_addr_nx;

   // Always true for power-of-two parameters; guards odd sizings.
   assign in_range  = (int'(submat_m) < NUM_SUBMATS_M) && (int'(submat_n) < NUM_SUBMATS_N);
   assign state_dbg = (state == DRAIN);

   always_comb begin
      state_nx  = state;
      t_nx      = t;
      m_nx      = m_q;
      n_nx      = n_q;
      acc_nx    = acc_q;
      active_nx = 1'b0;
      done_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (start && in_range) begin
               state_nx  = DRAIN;
               t_nx      = '0;
               m_nx      = submat_m;
               n_nx      = submat_n;
               acc_nx    = accum;
               active_nx = 1'b1;
            end
         end
         DRAIN: begin
            if (t == T_LAST) begin
               state_nx = IDLE;
               t_nx     = '0;
               done_nx  = 1'b1;
            end else begin
               t_nx      = t + T_W'(1);
               active_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are computed from next-state values so they register in step with t.
   always_comb begin
      wr_en_nx    = '0;
      accum_en_nx = '0;
      wr_addr_nx  = '0;
      base_nx     = ADDR_W'(n_nx) * ADDR_W'(MAX_OUT_ROWS) + ADDR_W'(m_nx) * ADDR_W'(SYS_ARR_ROWS);
      if (active_nx) begin
         for (int c = 0; c < SYS_ARR_COLS; c++) begin
            if (int'(t_nx) >= c && int'(t_nx) <= c + SYS_ARR_ROWS - 1) begin
               wr_en_nx[c]                    = 1'b1;
               accum_en_nx[c]                 = acc_nx;
               wr_addr_nx[c*ADDR_W +: ADDR_W] = base_nx + ADDR_W'(int'(t_nx) - c);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         t        <= '0;
         m_q      <= '0;
         n_q      <= '0;
         acc_q    <= 1'b0;
         wr_en    <= '0;
         wr_addr  <= '0;
         accum_en <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         t        <= t_nx;
         m_q      <= m_nx;
         n_q      <= n_nx;
         acc_q    <= acc_nx;
         wr_en    <= wr_en_nx;
         wr_addr  <= wr_addr_nx;
         accum_en <= accum_en_nx;
         busy     <= active_nx;
         done     <= done_nx;
      end
   end

endmodule
